// File: rtl/mem_block_arbiter.sv
// rtl/mem_block_arbiter.sv - I/D cache block-refill arbiter onto a single main-memory port
module mem_block_arbiter #(
   parameter int TIMEOUT = 255
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic         i_req,
   input  logic [31:0]  i_addr,
   output logic [255:0] i_block,
   output logic         i_done,
   input  logic         d_req,
   input  logic         d_we,
   input  logic [31:0]  d_addr,
   input  logic [255:0] d_wdata,
   output logic [255:0] d_block,
   output logic         d_done,
   output logic         mem_req,
   output logic         mem_we,
   output logic [31:0]  mem_addr,
   output logic [255:0] mem_wdata,
   input  logic [255:0] mem_rdata,
   input  logic         mem_ready,
   output logic         FREEZE,
   output logic         timeout_err
);

   typedef enum logic [2:0] {IDLE, I_RD, D_RD, D_WR, DONE} state_t;

   state_t      state, next_state;
   logic        last_grant_d;
   logic [7:0]  wait_cnt;
   logic [8:0]  cnt_inc;
   logic        busy, grant, grant_d, finish, timeout_ev;
   logic [31:0] sel_addr;

   assign mem_req = busy;
   assign FREEZE  = i_req | d_req | (state != IDLE);

   // Next-state logic: arbitration in IDLE, completion/timeout detection in BUSY states
   always_comb begin
      next_state = state;
      grant      = 1'b0;
      grant_d    = 1'b0;
      busy       = 1'b0;
      finish     = 1'b0;
      timeout_ev = 1'b0;
      cnt_inc    = {1'b0, wait_cnt} + 9'd1;
      case (state)
         IDLE: begin
            if (i_req || d_req) begin
               grant   = 1'b1;
               // D wins a tie unless it won the previous grant
               grant_d = d_req && (!i_req || !last_grant_d);
               if (grant_d) next_state = d_we ? D_WR : D_RD;
               else         next_state = I_RD;
            end
         end
         I_RD, D_RD, D_WR: begin
            busy = 1'b1;
            if (mem_ready) begin
               finish = 1'b1;
            end else if (cnt_inc == 9'(TIMEOUT)) begin
               finish     = 1'b1;
               timeout_ev = 1'b1;
            end
            if (finish) next_state = DONE;
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   assign sel_addr = grant_d ? d_addr : i_addr;

   // State register
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) state <= IDLE;
      else        state <= next_state;
   end

   // Capture the granted request and run the wait counter
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         last_grant_d <= 1'b0;
         mem_addr     <= '0;
         mem_we       <= 1'b0;
         mem_wdata    <= '0;
         wait_cnt     <= '0;
      end else if (grant) begin
         last_grant_d <= grant_d;
         mem_addr     <= {sel_addr[31:5], 5'b0};
         mem_we       <= grant_d & d_we;
         if (grant_d && d_we) mem_wdata <= d_wdata;
         wait_cnt     <= '0;
      end else if (busy && !mem_ready) begin
         wait_cnt <= cnt_inc[7:0];
      end
   end

   // Load refill blocks, pulse done on entry to DONE, latch sticky timeout
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         i_block     <= '0;
         d_block     <= '0;
         i_done      <= 1'b0;
         d_done      <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         i_done <= 1'b0;
         d_done <= 1'b0;
         if (finish) begin
            case (state)
               I_RD: begin
                  i_block <= timeout_ev ? '0 : mem_rdata;
                  i_done  <= 1'b1;
               end
               D_RD: begin
                  d_block <= timeout_ev ? '0 : mem_rdata;
                  d_done  <= 1'b1;
               end
               D_WR:    d_done <= 1'b1;
               default: ;
            endcase
         end
         if (timeout_ev) timeout_err <= 1'b1;
      end
   end

endmodule

// File: doc/mem_block_arbiter.md
MEM_BLOCK_ARBITER -- requirements
Module: mem_block_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: max BUSY cycles waiting for mem_ready before abort.
REQ-002 CLK  input  1  single clock; all state changes on rising edge.
REQ-003 RESET  input  1  asynchronous, active-low reset.
REQ-004 i_req  input  1  I-cache block-refill request, level, held until i_done.
REQ-005 i_addr  input  32  I-cache miss address.
REQ-006 i_block  output  256  refilled instruction block.
REQ-007 i_done  output  1  one-cycle completion pulse to the I-cache.
REQ-008 d_req  input  1  D-cache block request, level, held until d_done.
REQ-009 d_we  input  1  1 = write-back block, 0 = refill read.
REQ-010 d_addr  input  32  D-cache block address.
REQ-011 d_wdata  input  256  write-back block.
REQ-012 d_block  output  256  refilled data block.
REQ-013 d_done  output  1  one-cycle completion pulse to the D-cache.
REQ-014 mem_req  output  1  main-memory block request.
REQ-015 mem_we  output  1  main-memory write enable.
REQ-016 mem_addr  output  32  block-aligned memory address.
REQ-017 mem_wdata  output  256  block written to memory.
REQ-018 mem_rdata  input  256  block read from memory.
REQ-019 mem_ready  input  1  memory completion, sampled only in BUSY states.
REQ-020 FREEZE  output  1  pipeline stall.
REQ-021 timeout_err  output  1  sticky memory-timeout flag.

Function
REQ-022 FSM states: IDLE, I_RD, D_RD, D_WR, DONE; I_RD/D_RD/D_WR are the BUSY states.
REQ-023 In IDLE: i_req only -> I_RD; d_req only -> D_RD (d_we=0) or D_WR (d_we=1); neither -> stay IDLE.
REQ-024 In IDLE with both requests: grant D unless last_grant==D, then grant I; last_grant updates on every grant.
REQ-025 On grant: mem_addr latched as {addr[31:5],5'b0}, mem_wdata latched from d_wdata (D_WR only), mem_we latched as 1 for D_WR and 0 otherwise; later changes on request inputs are ignored.
REQ-026 mem_req is 1 in every BUSY state and 0 otherwise.
REQ-027 In a BUSY state, mem_ready=1 -> DONE; for I_RD/D_RD, mem_rdata is registered into i_block/d_block on that same edge.
REQ-028 In DONE: the matching i_done/d_done is 1 for exactly that cycle; the next state is always IDLE, and requests are not sampled in DONE.
REQ-029 Grant latency: request seen in IDLE -> mem_req=1 the next cycle; done pulse appears one cycle after the cycle in which mem_ready is seen.
REQ-030 Wait counter: 8-bit; cleared on grant; increments each BUSY cycle with mem_ready=0.
REQ-031 Timeout: counter reaches TIMEOUT in a BUSY state -> DONE, timeout_err set, target block register loaded with zero, done pulse still issued.
REQ-032 timeout_err is sticky; only RESET clears it.
REQ-033 FREEZE = i_req | d_req | (state != IDLE), combinational.
REQ-034 D_WR leaves d_block unchanged; i_block and d_block hold their value between refills.
REQ-035 Requesters drop req the cycle after done; a req still high in the following IDLE is treated as a new request.

Reset
REQ-036 RESET=0 asynchronously forces: state IDLE, last_grant=I, counter 0, mem_req/mem_we/i_done/d_done/timeout_err 0, mem_addr/mem_wdata/i_block/d_block 0.
REQ-037 RESET asserted mid-transaction aborts immediately: mem_req drops without waiting for a clock and no done pulse is issued; operation resumes from IDLE after release.

Verification
REQ-038 i_req=1, i_addr=0x0040_0024, mem_ready after 3 cycles with mem_rdata=A -> mem_addr=0x0040_0020, mem_we=0, i_block=A, one i_done pulse, FREEZE low once i_req drops.
REQ-039 i_req and d_req both raised in the same cycle after reset -> D served first, then I; a second simultaneous pair -> D then I again (alternation via last_grant).
REQ-040 d_req=1, d_we=1, d_addr=0x1000_003F, d_wdata=B -> mem_addr=0x1000_0020, mem_we=1, mem_wdata=B, d_done pulse, d_block unchanged.
REQ-041 d_req read with mem_ready held low, TIMEOUT=255 -> abort after 255 BUSY cycles, d_block=0, d_done=1, timeout_err=1 until the next reset.
REQ-042 RESET pulled low 2 cycles into I_RD -> mem_req=0 asynchronously, no i_done; after release with i_req still high -> fresh grant the next cycle.
